// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem -- parametrised APB4 completer memory model.
//
// A word-organised memory behind an APB4 completer interface with a fixed
// number of wait states per access, byte strobes, and PSLVERR on out-of-range
// addresses or on an access phase that arrives without a setup phase.
//
// Optional feature (macro APB_SLAVE_MEM_PROT_EN):
//   Adds PPROT[2:0]. A non-secure access (PPROT[1]=1) to the upper half of the
//   memory completes with PSLVERR=1, no write and PRDATA=0.
//
// Ports:
//   PCLK     in   clock, all state changes on the rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address (low byte-offset bits ignored)
//   PWDATA   in   write data
//   PSTRB    in   write byte strobes
//   PPROT    in   protection attributes (only with APB_SLAVE_MEM_PROT_EN)
//   PREADY   out  transfer completion (registered)
//   PRDATA   out  read data, zero outside the completion cycle (registered)
//   PSLVERR  out  transfer error, valid with PREADY (registered)
// -----------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          DATA_WIDTH  = 32,
    parameter int          MEM_DEPTH   = 256,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`ifdef APB_SLAVE_MEM_PROT_EN
    input  logic [2:0]              PPROT,
`endif
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int                    NBYTES = DATA_WIDTH / 8;
    localparam int                    OFF_W  = $clog2(NBYTES);
    localparam int                    IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [3:0]            WAIT4  = 4'(WAIT_CYCLES);

    // SETUP is the first access cycle (the one after the setup phase was
    // seen); ACCESS covers the remaining wait cycles and the completion cycle.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_ERR
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;      // PREADY-low cycles still to come, 0 = completing
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NBYTES-1:0]       strb_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

`ifdef APB_SLAVE_MEM_PROT_EN
    logic                    nonsec_q;
    logic                    dec_nonsec;
`endif

    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic [ADDR_WIDTH-1:0]   dec_idx_full;
    logic [IDX_W-1:0]        mem_idx;
    logic                    dec_write;
    logic                    dec_ok;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    rsp_err;

    // Decode looks at the live bus while idle (so a zero-wait response can be
    // registered at the setup edge) and at the captured copy afterwards.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        dec_addr     = (state == S_IDLE) ? PADDR  : addr_q;
        dec_write    = (state == S_IDLE) ? PWRITE : write_q;
        dec_idx_full = (dec_addr - BASE) >> OFF_W;
        mem_idx      = dec_idx_full[IDX_W-1:0];
        dec_ok       = (dec_addr >= BASE) && (32'(dec_idx_full) < 32'(MEM_DEPTH));
`ifdef APB_SLAVE_MEM_PROT_EN
        dec_nonsec = (state == S_IDLE) ? PPROT[1] : nonsec_q;
        if (dec_nonsec && (mem_idx >= IDX_W'(MEM_DEPTH / 2)))
            dec_ok = 1'b0;
`endif
        rsp_err  = !dec_ok;
        rsp_data = (dec_ok && !dec_write) ? mem[mem_idx] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
`ifdef APB_SLAVE_MEM_PROT_EN
            nonsec_q <= 1'b0;
`endif
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
            // NOTE: the memory is cleared by reset on purpose; the model must
            // come up all-zero, so it is built from resettable flops rather
            // than a RAM macro.
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            // Response outputs are a one-cycle pulse unless re-armed below.
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state   <= S_SETUP;
                        cnt     <= WAIT4;
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
`ifdef APB_SLAVE_MEM_PROT_EN
                        nonsec_q <= PPROT[1];
`endif
                        if (WAIT4 == 4'd0) begin
                            PREADY  <= 1'b1;
                            PRDATA  <= rsp_data;
                            PSLVERR <= rsp_err;
                        end
                    end else if (PSEL && PENABLE) begin
                        // Access phase without a setup phase.
                        state   <= S_ERR;
                        PREADY  <= 1'b1;
                        PSLVERR <= 1'b1;
                    end
                end

                S_SETUP, S_ACCESS: begin
                    if (!(PSEL && PENABLE)) begin
                        // Requester abandoned the transfer: no side effects.
                        state <= S_IDLE;
                    end else if (PREADY) begin
                        // Completion edge: commit the write with captured data.
                        if (write_q && dec_ok) begin
                            for (int b = 0; b < NBYTES; b++)
                                if (strb_q[b])
                                    mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                        state <= S_IDLE;
                    end else begin
                        state <= S_ACCESS;
                        cnt   <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            PREADY  <= 1'b1;
                            PRDATA  <= rsp_data;
                            PSLVERR <= rsp_err;
                        end
                    end
                end

                S_ERR: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
